multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have parameter REGISTER_WIDTH, default 64, meaning the data width of each register.
REQ-002 The block SHALL have parameter REGISTERNO_WIDTH, default 5, meaning the register-number width; the file holds 2**REGISTERNO_WIDTH registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning the number of read ports (1..4).
REQ-004 The block SHALL have parameter NUM_WR, default 2, meaning the number of write ports (1..2).
REQ-005 The block SHALL have parameter STACKPTR_RESET, default 64'h0, meaning the reset value of register 2.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low (0 = reset asserted).
REQ-008 The block SHALL have port in_rd_regno, input, NUM_RD*REGISTERNO_WIDTH bits: read addresses, with port k occupying slice k.
REQ-009 The block SHALL have port out_rd_value, output, NUM_RD*REGISTER_WIDTH bits: read data per port.
REQ-010 The block SHALL have port out_rd_busy, output, NUM_RD bits: scoreboard busy bit of each addressed register.
REQ-011 The block SHALL have ports in_wr_enable (NUM_WR bits), in_wr_regno (NUM_WR*REGISTERNO_WIDTH bits) and in_wr_value (NUM_WR*REGISTER_WIDTH bits), all inputs: the write ports.
REQ-012 The block SHALL have ports in_reserve_valid (1 bit) and in_reserve_regno (REGISTERNO_WIDTH bits), both inputs: mark a destination register busy at issue.
REQ-013 The block SHALL have port in_dump_req, input, 1 bit: start a sequential register dump.
REQ-014 The block SHALL have ports out_dump_valid (1 bit), out_dump_regno (REGISTERNO_WIDTH bits), out_dump_value (REGISTER_WIDTH bits) and out_dump_done (1 bit), all outputs: the dump stream.

Function
REQ-015 Reads SHALL be combinational; register 0 SHALL always read 0 and SHALL never be busy.
REQ-016 A write SHALL update its register at the rising edge when its enable is 1 and its regno is nonzero; writes to register 0 SHALL be discarded.
REQ-017 Two writes to the same register in one cycle SHALL commit write port NUM_WR-1 (highest index wins).
REQ-018 Busy bit SHALL be set at the edge where in_reserve_valid=1 for a nonzero regno, and cleared at the edge where any write targets that register.
REQ-019 A reserve and a write to the same register in the same cycle SHALL leave busy=1 (the reservation is for a newer producer).
REQ-020 The dump FSM SHALL have states IDLE, DUMP and DONE: IDLE->DUMP on in_dump_req=1; in DUMP a counter steps 0..2**REGISTERNO_WIDTH-1, one register per cycle; after the last register it SHALL go DUMP->DONE; DONE->IDLE unconditionally after one cycle.
REQ-021 In DUMP, out_dump_valid SHALL be 1, with out_dump_regno=counter and out_dump_value=the stored value (unbypassed); in DONE, out_dump_done SHALL be 1 for exactly one cycle.
REQ-022 in_dump_req SHALL be ignored outside IDLE; writes and reads SHALL continue normally during a dump.
REQ-023 All dump outputs SHALL be 0 in IDLE.

Reset
REQ-024 Reset assertion (reset=0) SHALL immediately clear all registers to 0 except register 2, which is set to STACKPTR_RESET; it SHALL clear all busy bits, set the FSM to IDLE with the counter at 0, and drive all dump outputs to 0.
REQ-025 Reset asserted mid-dump SHALL abort the dump with no out_dump_done pulse; writes presented during reset SHALL be lost.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: a read whose regno matches an enabled same-cycle nonzero write SHALL return that write data (the highest-index matching port) and busy=0.
REQ-027 Macro REGFILE_BYPASS_EN undefined: reads SHALL return stored values only, so a write becomes visible the cycle after the edge.

Verification
REQ-028 The bench SHALL cover reset deassert with STACKPTR_RESET=64'h8000: read port0 regno 2 -> 64'h8000; regno 5 -> 0.
REQ-029 The bench SHALL cover a write of port0 regno 0 value 64'h55, then a read of regno 0 -> 0 and busy=0.
REQ-030 The bench SHALL cover the same cycle writing port0 regno 7=64'h11 and port1 regno 7=64'h22: the next cycle reads 64'h22; with the macro defined the same-cycle read also returns 64'h22.
REQ-031 The bench SHALL cover reserve of regno 9 followed by a write of 9 one cycle later: busy 1 for one cycle then 0; a reserve and write of 9 in the same cycle -> busy stays 1.
REQ-032 The bench SHALL cover a 1-cycle pulse of in_dump_req: out_dump_valid high for 32 consecutive cycles with regno 0..31, then out_dump_done for exactly 1 cycle, then IDLE.
REQ-033 The bench SHALL cover reset asserted at dump counter 10: outputs go to 0 immediately, no out_dump_done pulse, and a new request after release starts at regno 0.

Source files
------------

// File: rtl/multiport_regfile.sv
// Multi-ported register file with per-register busy scoreboard and a sequential dump engine.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module multiport_regfile #(
  parameter int unsigned REGISTER_WIDTH   = 64,
  parameter int unsigned REGISTERNO_WIDTH = 5,
  parameter int unsigned NUM_RD           = 2,
  parameter int unsigned NUM_WR           = 2,
  parameter logic [REGISTER_WIDTH-1:0] STACKPTR_RESET = REGISTER_WIDTH'(64'h0)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RD*REGISTERNO_WIDTH-1:0]   in_rd_regno,
  output logic [NUM_RD*REGISTER_WIDTH-1:0]     out_rd_value,
  output logic [NUM_RD-1:0]                    out_rd_busy,
  input  logic [NUM_WR-1:0]                    in_wr_enable,
  input  logic [NUM_WR*REGISTERNO_WIDTH-1:0]   in_wr_regno,
  input  logic [NUM_WR*REGISTER_WIDTH-1:0]     in_wr_value,
  input  logic                                 in_reserve_valid,
  input  logic [REGISTERNO_WIDTH-1:0]          in_reserve_regno,
  input  logic                                 in_dump_req,
  output logic                                 out_dump_valid,
  output logic [REGISTERNO_WIDTH-1:0]          out_dump_regno,
  output logic [REGISTER_WIDTH-1:0]            out_dump_value,
  output logic                                 out_dump_done
);

  localparam int unsigned RW   = REGISTER_WIDTH;
  localparam int unsigned RNW  = REGISTERNO_WIDTH;
  localparam int unsigned NREG = 1 << REGISTERNO_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [RW-1:0]   regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [RNW-1:0]  wr_regno [NUM_WR];
  logic [RW-1:0]   wr_value [NUM_WR];
  logic [NUM_WR-1:0] wr_act;

  logic [1:0]     state_q, state_n;
  logic [RNW-1:0] cnt_q, cnt_n;

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_regno[w] = in_wr_regno[w*RNW +: RNW];
    assign wr_value[w] = in_wr_value[w*RW +: RW];
    assign wr_act[w]   = in_wr_enable[w] && (wr_regno[w] != '0);
  end

  // Storage; later write ports overwrite earlier ones on a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= (i == 2) ? STACKPTR_RESET : '0;
      end
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_act[w]) regs[wr_regno[w]] <= wr_value[w];
      end
    end
  end

  // Busy scoreboard; a reservation outranks a same-cycle completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_act[w]) busy_q[wr_regno[w]] <= 1'b0;
      end
      if (in_reserve_valid && (in_reserve_regno != '0)) busy_q[in_reserve_regno] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [RNW-1:0] addr;
    logic [RW-1:0]  val;
    logic           bsy;

    assign addr = in_rd_regno[k*RNW +: RNW];

    always_comb begin
      val = regs[addr];
      bsy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_act[w] && (wr_regno[w] == addr)) begin
          val = wr_value[w];
          bsy = 1'b0;
        end
      end
`endif
      if (addr == '0) begin
        val = '0;
        bsy = 1'b0;
      end
    end

    assign out_rd_value[k*RW +: RW] = val;
    assign out_rd_busy[k]           = bsy;
  end

  // Dump FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_dump_req) begin
          state_n = DUMP;
          cnt_n   = '0;
        end
      end
      DUMP: begin
        cnt_n = cnt_q + RNW'(1);
        if (&cnt_q) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign out_dump_valid = (state_q == DUMP);
  assign out_dump_done  = (state_q == DONE);
  assign out_dump_regno = out_dump_valid ? cnt_q : '0;
  assign out_dump_value = out_dump_valid ? regs[cnt_q] : '0;

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: reads, writes, busy tracking, dump stream and dump abort.
module tb_multiport_regfile;

  localparam int unsigned RW  = 64;
  localparam int unsigned RNW = 5;

  typedef struct {
    logic [RW-1:0] value;
    logic          busy;
  } rd_exp_t;

  typedef struct {
    logic           valid;
    logic           done;
    logic [RNW-1:0] regno;
    logic [RW-1:0]  value;
  } dump_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*RNW-1:0]  rd_regno;
  logic [2*RW-1:0]   rd_value;
  logic [1:0]        rd_busy;
  logic [1:0]        wr_enable;
  logic [2*RNW-1:0]  wr_regno;
  logic [2*RW-1:0]   wr_value;
  logic              reserve_valid;
  logic [RNW-1:0]    reserve_regno;
  logic              dump_req;
  logic              dump_valid;
  logic [RNW-1:0]    dump_regno;
  logic [RW-1:0]     dump_value;
  logic              dump_done;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] model [32];
  rd_exp_t   rq [$];
  dump_exp_t dq [$];

  always #5 clk = ~clk;

  multiport_regfile #(
    .REGISTER_WIDTH(RW), .REGISTERNO_WIDTH(RNW), .NUM_RD(2), .NUM_WR(2),
    .STACKPTR_RESET(64'h8000)
  ) dut (
    .clk(clk), .reset(reset),
    .in_rd_regno(rd_regno), .out_rd_value(rd_value), .out_rd_busy(rd_busy),
    .in_wr_enable(wr_enable), .in_wr_regno(wr_regno), .in_wr_value(wr_value),
    .in_reserve_valid(reserve_valid), .in_reserve_regno(reserve_regno),
    .in_dump_req(dump_req),
    .out_dump_valid(dump_valid), .out_dump_regno(dump_regno),
    .out_dump_value(dump_value), .out_dump_done(dump_done)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model[2] = 64'h8000;
  endtask

  task automatic test_reset();
    rd_exp_t e;
    reset = 1'b0; wr_enable = '0; wr_regno = '0; wr_value = '0;
    reserve_valid = 1'b0; reserve_regno = '0; dump_req = 1'b0;
    rd_regno = {5'd5, 5'd2};
    model_reset();
    repeat (2) @(negedge clk);
    rq.push_back('{64'h8000, 1'b0});
    rq.push_back('{64'h0, 1'b0});
    reset = 1'b1;
    @(negedge clk); #1;
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value || rd_busy[0] !== e.busy) begin
      bad++; $display("FAIL reset_reg2 got=%h/%b exp=%h/%b", rd_value[63:0], rd_busy[0], e.value, e.busy);
    end
    e = rq.pop_front(); total++;
    if (rd_value[127:64] !== e.value || rd_busy[1] !== e.busy) begin
      bad++; $display("FAIL reset_reg5 got=%h/%b exp=%h/%b", rd_value[127:64], rd_busy[1], e.value, e.busy);
    end
    total++;
    if ({dump_valid, dump_done, dump_regno, dump_value} !== '0) begin
      bad++; $display("FAIL reset_dump_idle got=%b%b %h %h exp=0", dump_valid, dump_done, dump_regno, dump_value);
    end
  endtask

  task automatic test_zero_write();
    rd_exp_t e;
    @(negedge clk);
    wr_enable = 2'b01; wr_regno = {5'd0, 5'd0}; wr_value = {64'h0, 64'h55};
    rd_regno = {5'd0, 5'd0};
    rq.push_back('{64'h0, 1'b0});
    #1;
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value || rd_busy[0] !== e.busy) begin
      bad++; $display("FAIL zero_same_cycle got=%h/%b exp=%h/%b", rd_value[63:0], rd_busy[0], e.value, e.busy);
    end
    @(negedge clk);
    wr_enable = '0;
    rq.push_back('{64'h0, 1'b0});
    #1;
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value || rd_busy[0] !== e.busy) begin
      bad++; $display("FAIL zero_after got=%h/%b exp=%h/%b", rd_value[63:0], rd_busy[0], e.value, e.busy);
    end
  endtask

  task automatic test_write_collision();
    rd_exp_t e;
    @(negedge clk);
    wr_enable = 2'b11; wr_regno = {5'd7, 5'd7}; wr_value = {64'h22, 64'h11};
    rd_regno = {5'd7, 5'd7};
`ifdef REGFILE_BYPASS_EN
    rq.push_back('{64'h22, 1'b0});
`else
    rq.push_back('{64'h0, 1'b0});
`endif
    #1;
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL collide_same_cycle got=%h exp=%h", rd_value[63:0], e.value);
    end
    @(negedge clk);
    wr_enable = '0;
    model[7] = 64'h22;
    rq.push_back('{model[7], 1'b0});
    rq.push_back('{model[7], 1'b0});
    #1;
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL collide_next_p0 got=%h exp=%h", rd_value[63:0], e.value);
    end
    e = rq.pop_front(); total++;
    if (rd_value[127:64] !== e.value) begin
      bad++; $display("FAIL collide_next_p1 got=%h exp=%h", rd_value[127:64], e.value);
    end
  endtask

  task automatic test_reserve();
    rd_exp_t e;
    @(negedge clk);
    rd_regno = {5'd0, 5'd9};
    reserve_valid = 1'b1; reserve_regno = 5'd9;
    @(negedge clk);
    reserve_valid = 1'b0;
    rq.push_back('{64'h0, 1'b1});
    #1;
    e = rq.pop_front(); total++;
    if (rd_busy[0] !== e.busy) begin
      bad++; $display("FAIL reserve_busy_set got=%b exp=%b", rd_busy[0], e.busy);
    end
    wr_enable = 2'b01; wr_regno = {5'd0, 5'd9}; wr_value = {64'h0, 64'h99};
    @(negedge clk);
    wr_enable = '0;
    model[9] = 64'h99;
    rq.push_back('{model[9], 1'b0});
    #1;
    e = rq.pop_front(); total++;
    if (rd_busy[0] !== e.busy || rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL reserve_busy_clear got=%h/%b exp=%h/%b", rd_value[63:0], rd_busy[0], e.value, e.busy);
    end
    reserve_valid = 1'b1; reserve_regno = 5'd9;
    wr_enable = 2'b10; wr_regno = {5'd9, 5'd0}; wr_value = {64'hAA, 64'h0};
    @(negedge clk);
    reserve_valid = 1'b0; wr_enable = '0;
    model[9] = 64'hAA;
    rq.push_back('{model[9], 1'b1});
    #1;
    e = rq.pop_front(); total++;
    if (rd_busy[0] !== e.busy || rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL reserve_and_write got=%h/%b exp=%h/%b", rd_value[63:0], rd_busy[0], e.value, e.busy);
    end
    // Retire the pending reservation so later checks start clean.
    wr_enable = 2'b01; wr_regno = {5'd0, 5'd9}; wr_value = {64'h0, model[9]};
    @(negedge clk);
    wr_enable = '0;
  endtask

  task automatic run_dump_stream(input string tag);
    dump_exp_t e;
    dump_req = 1'b1;
    for (int r = 0; r < 32; r++) dq.push_back('{1'b1, 1'b0, 5'(r), model[r]});
    dq.push_back('{1'b0, 1'b1, 5'd0, 64'h0});
    dq.push_back('{1'b0, 1'b0, 5'd0, 64'h0});
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      dump_req = 1'b0;
      #1;
      e = dq.pop_front(); total++;
      if (dump_valid !== e.valid || dump_done !== e.done || dump_regno !== e.regno || dump_value !== e.value) begin
        bad++;
        $display("FAIL %s cyc%0d got=%b%b %0d %h exp=%b%b %0d %h", tag, i,
                 dump_valid, dump_done, dump_regno, dump_value, e.valid, e.done, e.regno, e.value);
      end
    end
  endtask

  task automatic test_dump();
    for (int r = 1; r < 32; r += 2) begin
      @(negedge clk);
      wr_enable = (r < 31) ? 2'b11 : 2'b01;
      wr_regno  = {5'(r + 1), 5'(r)};
      wr_value  = {64'hB000_0000_0000_0000 + 64'(r + 1), 64'hA000_0000_0000_0000 + 64'(r)};
      model[r] = 64'hA000_0000_0000_0000 + 64'(r);
      if (r < 31) model[r + 1] = 64'hB000_0000_0000_0000 + 64'(r + 1);
    end
    @(negedge clk);
    wr_enable = '0;
    run_dump_stream("dump_full");
  endtask

  task automatic test_dump_abort();
    rd_exp_t e;
    bit found = 1'b0;
    @(negedge clk);
    dump_req = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      dump_req = 1'b0;
      #1;
      if (dump_valid && dump_regno == 5'd10) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL abort_reach10 got=not_seen exp=regno10");
    end
    reset = 1'b0;
    wr_enable = 2'b01; wr_regno = {5'd0, 5'd3}; wr_value = {64'h0, 64'h33};
    rd_regno = {5'd7, 5'd2};
    model_reset();
    rq.push_back('{model[2], 1'b0});
    rq.push_back('{model[7], 1'b0});
    #1;
    total++;
    if ({dump_valid, dump_done, dump_regno, dump_value} !== '0) begin
      bad++; $display("FAIL abort_outputs got=%b%b %h %h exp=0", dump_valid, dump_done, dump_regno, dump_value);
    end
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL abort_reg2 got=%h exp=%h", rd_value[63:0], e.value);
    end
    e = rq.pop_front(); total++;
    if (rd_value[127:64] !== e.value) begin
      bad++; $display("FAIL abort_reg7 got=%h exp=%h", rd_value[127:64], e.value);
    end
    @(negedge clk);
    wr_enable = '0;
    reset = 1'b1;
    rd_regno = {5'd0, 5'd3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        bad++; $display("FAIL abort_no_done cyc%0d got=%b%b exp=00", i, dump_valid, dump_done);
      end
    end
    rq.push_back('{64'h0, 1'b0});
    e = rq.pop_front(); total++;
    if (rd_value[63:0] !== e.value) begin
      bad++; $display("FAIL abort_write_lost got=%h exp=%h", rd_value[63:0], e.value);
    end
    @(negedge clk);
    run_dump_stream("dump_restart");
  endtask

  initial begin
    test_reset();
    test_zero_write();
    test_write_collision();
    test_reserve();
    test_dump();
    test_dump_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
